// File: rtl/irq_pkg.sv
// Shared types and constants for the simple interrupt controller.
package irq_pkg;

    localparam int MAX_SRC = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_ENABLE   = 2'd0;
    localparam logic [1:0] ADDR_PENDING  = 2'd1;
    localparam logic [1:0] ADDR_OVERFLOW = 2'd2;
    localparam logic [1:0] ADDR_STATUS   = 2'd3;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: request vector -> valid + index.
module irq_prio_enc #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    output logic           vld_o,
    output logic [IDW-1:0] id_o
);

    always_comb begin
        vld_o = |req_i;
        id_o  = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) id_o = IDW'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl_simple.sv
// Collects irq pulses into pending bits, arbitrates lowest enabled index,
// and presents one request at a time to the core via claim/complete.
module irq_ctrl_simple
    import irq_pkg::*;
#(
    parameter  int NSRC = 4,
    localparam int IDW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] src_i,
    input  logic            cfg_we_i,
    input  logic [1:0]      cfg_addr_i,
    input  logic [31:0]     cfg_wdata_i,
    output logic [31:0]     cfg_rdata_o,
    output logic            irq_o,
    output logic [IDW-1:0]  irq_id_o,
    input  logic            claim_i,
    input  logic            complete_i
);

    logic [NSRC-1:0] src_q, enable_q, enable_d, pending_q, pending_d, overflow_q, overflow_d;
    logic [NSRC-1:0] rise, claim_clr, pend_clr, wdata;
    logic            irq_q, irq_d;
    logic [IDW-1:0]  id_q, id_d, enc_id;
    logic            enc_vld, claim_fire;
    state_e          state_q, state_d;

    assign wdata = cfg_wdata_i[NSRC-1:0];
    assign rise  = src_i & ~src_q;

    if (NSRC < MAX_SRC) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^cfg_wdata_i[MAX_SRC-1:NSRC];
    end

    irq_prio_enc #(.N(NSRC), .IDW(IDW)) u_prio_enc (
        .req_i (pending_q & enable_q),
        .vld_o (enc_vld),
        .id_o  (enc_id)
    );

    // A new rise always wins over a clear landing in the same cycle.
    always_comb begin
        claim_fire = (state_q == ST_REQ) && claim_i;
        for (int i = 0; i < NSRC; i++) begin
            claim_clr[i] = claim_fire && (id_q == IDW'(i));
        end
        pend_clr   = claim_clr | ((cfg_we_i && cfg_addr_i == ADDR_PENDING) ? wdata : '0);
        pending_d  = (pending_q & ~pend_clr) | rise;
        overflow_d = (overflow_q & ~((cfg_we_i && cfg_addr_i == ADDR_OVERFLOW) ? wdata : '0))
                   | (rise & pending_q & ~pend_clr);
        enable_d   = (cfg_we_i && cfg_addr_i == ADDR_ENABLE) ? wdata : enable_q;
    end

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                irq_d = 1'b0;
                if (enc_vld) begin
                    state_d = ST_REQ;
                    irq_d   = 1'b1;
                    id_d    = enc_id;
                end
            end
            ST_REQ: begin
                if (claim_i) begin
                    state_d = ST_ACTIVE;
                    irq_d   = 1'b0;
                end else if (!pending_q[id_q] || !enable_q[id_q]) begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end
            end
            ST_ACTIVE: begin
                irq_d = 1'b0;
                if (complete_i) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q      <= '0;
            enable_q   <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
            state_q    <= ST_IDLE;
            irq_q      <= 1'b0;
            id_q       <= '0;
        end else begin
            src_q      <= src_i;
            enable_q   <= enable_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            irq_q      <= irq_d;
            id_q       <= id_d;
        end
    end

    always_comb begin
        cfg_rdata_o = '0;
        case (cfg_addr_i)
            ADDR_ENABLE:   cfg_rdata_o[NSRC-1:0] = enable_q;
            ADDR_PENDING:  cfg_rdata_o[NSRC-1:0] = pending_q;
            ADDR_OVERFLOW: cfg_rdata_o[NSRC-1:0] = overflow_q;
            default: begin
                cfg_rdata_o[1:0]      = state_q;
                cfg_rdata_o[8 +: IDW] = id_q;
                cfg_rdata_o[31:16]    = 16'(NSRC);
            end
        endcase
    end

    assign irq_o    = irq_q;
    assign irq_id_o = id_q;

endmodule

// File: tb/tb_irq_ctrl_simple.sv
// Directed bench for irq_ctrl_simple; expectations go through a scoreboard queue.
module tb_irq_ctrl_simple;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  src_i = '0;
    logic        cfg_we_i = 1'b0;
    logic [1:0]  cfg_addr_i = '0;
    logic [31:0] cfg_wdata_i = '0;
    logic [31:0] cfg_rdata_o;
    logic        irq_o;
    logic [1:0]  irq_id_o;
    logic        claim_i = 1'b0;
    logic        complete_i = 1'b0;

    localparam logic [1:0] A_EN = 2'd0, A_PEND = 2'd1, A_OVF = 2'd2, A_STAT = 2'd3;
    localparam logic [31:0] NS = 32'h0004_0000;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    irq_ctrl_simple #(.NSRC(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_i       (src_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_wdata_i (cfg_wdata_i),
        .cfg_rdata_o (cfg_rdata_o),
        .irq_o       (irq_o),
        .irq_id_o    (irq_id_o),
        .claim_i     (claim_i),
        .complete_i  (complete_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] v);
        sb_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] expd;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s obs=%0h exp=<scoreboard empty>", tag, obs);
        end else begin
            expd = sb_q.pop_front();
            assert (obs === expd) else begin
                errors++;
                $error("FAIL %s obs=%0h exp=%0h", tag, obs, expd);
            end
        end
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] v);
        push(v);
        cfg_addr_i = addr;
        #1;
        chk(tag, cfg_rdata_o);
    endtask

    // irq_o in bit 4, irq_id_o in bits 1:0
    task automatic out_chk(input string tag, input logic irq, input logic [1:0] id);
        push({27'd0, irq, 2'd0, id});
        chk(tag, {27'd0, irq_o, 2'd0, irq_id_o});
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        cfg_we_i = 1'b1; cfg_addr_i = addr; cfg_wdata_i = data;
        tick();
        cfg_we_i = 1'b0; cfg_wdata_i = '0;
    endtask

    task automatic pulse(input logic [3:0] m);
        src_i = m;
        tick();
        src_i = '0;
    endtask

    task automatic do_claim();
        claim_i = 1'b1; tick(); claim_i = 1'b0;
    endtask

    task automatic do_complete();
        complete_i = 1'b1; tick(); complete_i = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(2);
        out_chk("rst_out", 1'b0, 2'd0);
        rd_chk("rst_status", A_STAT, NS);
        rd_chk("rst_enable", A_EN, 32'h0);
        rd_chk("rst_pending", A_PEND, 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: single source, full latency and handshake
        cfg_write(A_EN, 32'hF);
        tick(6);
        pulse(4'b0100);
        rd_chk("t1_pend", A_PEND, 32'h4);
        out_chk("t1_n1", 1'b0, 2'd0);
        tick();
        out_chk("t1_n2", 1'b1, 2'd2);
        rd_chk("t1_req_status", A_STAT, NS | 32'h0201);
        do_claim();
        rd_chk("t1_claim_pend", A_PEND, 32'h0);
        rd_chk("t1_active", A_STAT, NS | 32'h0202);
        out_chk("t1_active_out", 1'b0, 2'd2);
        do_complete();
        rd_chk("t1_idle", A_STAT, NS | 32'h0200);
        tick();
        out_chk("t1_idle_out", 1'b0, 2'd2);

        // 2: priority and back-to-back service
        pulse(4'b1010);
        rd_chk("t2_pend", A_PEND, 32'hA);
        tick();
        out_chk("t2_first", 1'b1, 2'd1);
        do_claim();
        rd_chk("t2_pend_after", A_PEND, 32'h8);
        do_complete();
        out_chk("t2_idle_gap", 1'b0, 2'd1);
        tick();
        out_chk("t2_second", 1'b1, 2'd3);
        do_claim();
        do_complete();
        rd_chk("t2_pend_empty", A_PEND, 32'h0);

        // 3: pending latches regardless of enable
        cfg_write(A_EN, 32'h0);
        pulse(4'b0001);
        rd_chk("t3_pend", A_PEND, 32'h1);
        tick(3);
        out_chk("t3_masked", 1'b0, 2'd3);
        cfg_write(A_EN, 32'h1);
        out_chk("t3_w1", 1'b0, 2'd3);
        tick();
        out_chk("t3_w2", 1'b1, 2'd0);
        do_claim();
        do_complete();

        // 4: overflow and rise-vs-claim collision
        pulse(4'b0010);
        tick();
        pulse(4'b0010);
        rd_chk("t4_ovf", A_OVF, 32'h2);
        cfg_write(A_OVF, 32'h2);
        rd_chk("t4_ovf_w1c", A_OVF, 32'h0);
        cfg_write(A_EN, 32'h2);
        tick();
        out_chk("t4_req", 1'b1, 2'd1);
        src_i = 4'b0010; claim_i = 1'b1;
        tick();
        src_i = '0; claim_i = 1'b0;
        rd_chk("t4_coll_pend", A_PEND, 32'h2);
        rd_chk("t4_coll_ovf", A_OVF, 32'h0);
        rd_chk("t4_coll_state", A_STAT, NS | 32'h0102);
        do_complete();
        tick();
        out_chk("t4_rereq", 1'b1, 2'd1);
        do_claim();
        do_complete();

        // 5: withdrawn request, then claim racing the withdrawal
        cfg_write(A_EN, 32'h1);
        pulse(4'b0001);
        tick();
        out_chk("t5_req", 1'b1, 2'd0);
        cfg_write(A_PEND, 32'h1);
        rd_chk("t5_w1c_pend", A_PEND, 32'h0);
        tick();
        rd_chk("t5_drop_state", A_STAT, NS);
        out_chk("t5_drop_out", 1'b0, 2'd0);
        pulse(4'b0001);
        tick();
        out_chk("t5_req2", 1'b1, 2'd0);
        cfg_we_i = 1'b1; cfg_addr_i = A_PEND; cfg_wdata_i = 32'h1; claim_i = 1'b1;
        tick();
        cfg_we_i = 1'b0; cfg_wdata_i = '0; claim_i = 1'b0;
        rd_chk("t5_claim_wins", A_STAT, NS | 32'h0002);
        do_complete();

        // 6: async reset mid-service, stray handshakes, held level
        pulse(4'b0001);
        tick();
        do_claim();
        pulse(4'b0010);
        rd_chk("t6_active", A_STAT, NS | 32'h0002);
        rst_n = 1'b0;
        #1;
        out_chk("t6_rst_out", 1'b0, 2'd0);
        rd_chk("t6_rst_status", A_STAT, NS);
        rd_chk("t6_rst_pend", A_PEND, 32'h0);
        rd_chk("t6_rst_en", A_EN, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        do_claim();
        rd_chk("t6_stray_claim", A_STAT, NS);
        do_complete();
        rd_chk("t6_stray_complete", A_STAT, NS);
        src_i = 4'b0001;
        tick(4);
        src_i = '0;
        rd_chk("t6_level_pend", A_PEND, 32'h1);
        rd_chk("t6_level_ovf", A_OVF, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
